// File: rtl/pacote_paridade.sv
// Shared types and helpers for the serial even/odd parity generator and detector.
package pacote_paridade;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } estado_tx_t;

  localparam int unsigned DATA_W_DEFAULT = 8;

  // XOR of the low n bits of v.
  function automatic logic paridade_par(input logic [31:0] v, input int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) p = p ^ v[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/gerador_paridade_serial.sv
// Serial transmitter: shifts a word out LSB first and appends a parity bit.
module gerador_paridade_serial
  import pacote_paridade::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic              ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_last
);

  localparam int unsigned           CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_W - 1);

  estado_tx_t        state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              par, par_n;
  logic              out_bit_n, out_valid_n, out_last_n, ready_n;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      par       <= par_n;
      out_bit   <= out_bit_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      ready     <= ready_n;
    end
  end

  // Next state; PARITY accepts a new word so frames can run back to back.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    par_n   = par;
    unique case (state)
      IDLE, PARITY: begin
        if (start) begin
          shreg_n = data_in;
          cnt_n   = '0;
          par_n   = ODD_PARITY;
          state_n = DATA;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        shreg_n = shreg >> 1;
        par_n   = par ^ shreg[0];
        cnt_n   = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_n = PARITY;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they flop alongside it.
  always_comb begin
    out_bit_n   = 1'b0;
    out_valid_n = 1'b0;
    out_last_n  = 1'b0;
    ready_n     = 1'b1;
    unique case (state_n)
      DATA: begin
        out_valid_n = 1'b1;
        out_bit_n   = shreg_n[0];
        ready_n     = 1'b0;
      end
      PARITY: begin
        out_valid_n = 1'b1;
        out_last_n  = 1'b1;
        out_bit_n   = par_n;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gerador_paridade_serial.sv
// Scoreboard bench for gerador_paridade_serial (even and odd parity instances).
module tb_gerador_paridade_serial;
  import pacote_paridade::*;

  localparam int unsigned DW = 8;

  typedef struct {
    logic b;
    logic last;
    int   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic          ready0, out_bit0, out_valid0, out_last0;
  logic          ready1, out_bit1, out_valid1, out_last1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  gerador_paridade_serial #(.DATA_W(DW), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .reset(reset), .data_in(data0), .start(start0),
    .ready(ready0), .out_bit(out_bit0), .out_valid(out_valid0), .out_last(out_last0)
  );

  gerador_paridade_serial #(.DATA_W(DW), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .data_in(data1), .start(start1),
    .ready(ready1), .out_bit(out_bit1), .out_valid(out_valid1), .out_last(out_last1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the even instance.
  always @(negedge clk) begin
    if (out_valid0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL even_unexpected: got bit=%0b at cyc %0d, expected no output", out_bit0, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (out_bit0 !== e.b || out_last0 !== e.last || ready0 !== e.last || cyc != e.cyc) begin
          bad++;
          $display("FAIL even_bit: got bit=%0b last=%0b ready=%0b cyc=%0d expected bit=%0b last=%0b ready=%0b cyc=%0d",
                   out_bit0, out_last0, ready0, cyc, e.b, e.last, e.last, e.cyc);
        end
      end
    end
  end

  // Monitor for the odd instance.
  always @(negedge clk) begin
    if (out_valid1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL odd_unexpected: got bit=%0b at cyc %0d, expected no output", out_bit1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (out_bit1 !== e.b || out_last1 !== e.last || ready1 !== e.last || cyc != e.cyc) begin
          bad++;
          $display("FAIL odd_bit: got bit=%0b last=%0b ready=%0b cyc=%0d expected bit=%0b last=%0b ready=%0b cyc=%0d",
                   out_bit1, out_last1, ready1, cyc, e.b, e.last, e.last, e.cyc);
        end
      end
    end
  end

  task automatic push_frame(input bit sel, input logic [DW-1:0] d, input logic p, input int base);
    exp_t e;
    for (int i = 0; i < int'(DW); i++) begin
      e.b = d[i];
      e.last = 1'b0;
      e.cyc = base + i;
      if (sel) q1.push_back(e); else q0.push_back(e);
    end
    e.b = p;
    e.last = 1'b1;
    e.cyc = base + int'(DW);
    if (sel) q1.push_back(e); else q0.push_back(e);
  endtask

  // Called at posedge+1; returns cyc value during the first data bit.
  task automatic accept(input bit sel, input logic [DW-1:0] d, output int base);
    int guard;
    guard = 0;
    while (!(sel ? ready1 : ready0) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=0 for 50 cycles, expected ready=1");
    end
    if (sel) begin start1 = 1'b1; data1 = d; end
    else     begin start0 = 1'b1; data0 = d; end
    @(posedge clk); #1;
    base = cyc;
    if (sel) begin start1 = 1'b0; data1 = '0; end
    else     begin start0 = 1'b0; data0 = '0; end
  endtask

  task automatic send(input bit sel, input logic [DW-1:0] d, input logic p);
    int b;
    accept(sel, d, b);
    push_frame(sel, d, p, b);
    repeat (DW + 1) begin @(posedge clk); #1; end
  endtask

  initial begin
    int b;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_even", int'(ready0), 1);
    chk("rst_valid_even", int'(out_valid0), 0);
    chk("rst_ready_odd", int'(ready1), 1);
    chk("rst_valid_odd", int'(out_valid1), 0);
    reset = 1'b1;

    // Idle after release.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("idle_ready", int'(ready0), 1);
      chk("idle_valid", int'(out_valid0), 0);
      chk("idle_bit", int'(out_bit0), 0);
    end

    // Directed words.
    send(1'b0, 8'hB5, 1'b1);
    send(1'b0, 8'h00, 1'b0);
    send(1'b0, 8'hFF, 1'b0);
    send(1'b1, 8'h00, 1'b1);
    send(1'b1, 8'hFF, 1'b1);
    send(1'b1, 8'hB5, 1'b0);

    // Back-to-back: second start arrives during the first frame's parity cycle.
    accept(1'b0, 8'h01, b);
    push_frame(1'b0, 8'h01, 1'b1, b);
    push_frame(1'b0, 8'h03, 1'b0, b + int'(DW) + 1);
    repeat (DW) begin @(posedge clk); #1; end
    chk("b2b_ready_in_parity", int'(ready0), 1);
    start0 = 1'b1;
    data0 = 8'h03;
    @(posedge clk); #1;
    start0 = 1'b0;
    data0 = '0;
    repeat (DW + 1) begin @(posedge clk); #1; end

    // Start pulse while busy is ignored.
    accept(1'b0, 8'h0F, b);
    push_frame(1'b0, 8'h0F, 1'b0, b);
    repeat (2) begin @(posedge clk); #1; end
    start0 = 1'b1;
    data0 = 8'hFF;
    @(posedge clk); #1;
    start0 = 1'b0;
    data0 = '0;
    repeat (6) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("busy_no_extra_valid", int'(out_valid0), 0);
    end
    chk("busy_queue_empty", q0.size(), 0);

    // Asynchronous reset during data bit 4.
    accept(1'b0, 8'hA6, b);
    push_frame(1'b0, 8'hA6, 1'b0, b);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid0), 0);
    chk("midrst_ready", int'(ready0), 1);
    chk("midrst_last", int'(out_last0), 0);
    chk("midrst_remaining", q0.size(), 5);
    q0.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", int'(ready0), 1);
    chk("postrst_valid", int'(out_valid0), 0);
    send(1'b0, 8'h81, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    chk("final_queue_even", q0.size(), 0);
    chk("final_queue_odd", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
